// File: rtl/video_mda_glyph_fetch_if.sv
// Bundle of signals around the MDA glyph fetch stage: the cell stream in,
// the font ROM read port, blink control and the pixel stream out.
interface video_mda_glyph_fetch_if #(
   parameter int CHAR_WIDTH = 8,
   parameter int ROW_WIDTH  = 3
);
   logic                            s_cell_valid;
   logic                            s_cell_ready;
   logic [CHAR_WIDTH-1:0]           s_cell_char;
   logic [7:0]                      s_cell_attr;
   logic [ROW_WIDTH-1:0]            s_cell_row;
   logic                            s_cell_last;

   logic                            rom_re;
   logic [CHAR_WIDTH+ROW_WIDTH-1:0] rom_raddr;
   logic [7:0]                      rom_q;

   logic                            blink_en;
   logic                            blink_phase;

   logic                            m_pix_valid;
   logic                            m_pix_ready;
   logic [7:0]                      m_pix_bits;
   logic [7:0]                      m_pix_attr;
   logic                            m_pix_last;

   // Environment side: supplies cells, ROM data and blink state, consumes pixels.
   modport master (
      output s_cell_valid, s_cell_char, s_cell_attr, s_cell_row, s_cell_last,
      input  s_cell_ready,
      input  rom_re, rom_raddr,
      output rom_q,
      output blink_en, blink_phase,
      input  m_pix_valid, m_pix_bits, m_pix_attr, m_pix_last,
      output m_pix_ready
   );

   modport slave (
      input  s_cell_valid, s_cell_char, s_cell_attr, s_cell_row, s_cell_last,
      output s_cell_ready,
      output rom_re, rom_raddr,
      input  rom_q,
      input  blink_en, blink_phase,
      output m_pix_valid, m_pix_bits, m_pix_attr, m_pix_last,
      input  m_pix_ready
   );
endinterface

// File: rtl/video_mda_glyph_fetch.sv
// Two-stage MDA glyph fetch: stage 1 waits on the font ROM read, stage 2 holds
// the attribute-processed foreground bits for the pixel consumer.
module video_mda_glyph_fetch #(
   parameter int CHAR_WIDTH = 8,
   parameter int ROW_WIDTH  = 3,
   parameter int UL_ROW     = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   video_mda_glyph_fetch_if.slave       bus
);
   logic                 rd_pend;
   logic [7:0]           s1_attr;
   logic [ROW_WIDTH-1:0] s1_row;
   logic                 s1_last;

   logic                 pix_valid;
   logic [7:0]           pix_bits;
   logic [7:0]           pix_attr;
   logic                 pix_last;

   logic                 advance;
   logic                 in_xfer;
   logic                 cell_ready;
   logic [7:0]           glyph;

   assign advance    = rd_pend & (~pix_valid | bus.m_pix_ready);
   assign cell_ready = ~rst & (~rd_pend | advance);
   assign in_xfer    = bus.s_cell_valid & cell_ready;

   // A stalled stage 1 blocks new reads, so rom_q stays on the held entry's row.
   assign bus.s_cell_ready = cell_ready;
   assign bus.rom_re       = in_xfer;
   assign bus.rom_raddr    = {bus.s_cell_char, bus.s_cell_row};

   assign bus.m_pix_valid  = pix_valid;
   assign bus.m_pix_bits   = pix_bits;
   assign bus.m_pix_attr   = pix_attr;
   assign bus.m_pix_last   = pix_last;

   // Later rules override earlier ones: underline, blink-off, reverse, invisible.
   always_comb begin
      glyph = bus.rom_q;
      if (s1_attr[2:0] == 3'b001 && s1_row == ROW_WIDTH'(UL_ROW))
         glyph = 8'hFF;
      if (bus.blink_en && s1_attr[7] && bus.blink_phase)
         glyph = 8'h00;
      if ((s1_attr & 8'h77) == 8'h70)
         glyph = ~glyph;
      if ((s1_attr & 8'h77) == 8'h00)
         glyph = 8'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend   <= 1'b0;
         s1_attr   <= '0;
         s1_row    <= '0;
         s1_last   <= 1'b0;
         pix_valid <= 1'b0;
         pix_bits  <= '0;
         pix_attr  <= '0;
         pix_last  <= 1'b0;
      end else begin
         if (in_xfer) begin
            rd_pend <= 1'b1;
            s1_attr <= bus.s_cell_attr;
            s1_row  <= bus.s_cell_row;
            s1_last <= bus.s_cell_last;
         end else if (advance) begin
            rd_pend <= 1'b0;
         end

         if (advance) begin
            pix_valid <= 1'b1;
            pix_bits  <= glyph;
            pix_attr  <= s1_attr;
            pix_last  <= s1_last;
         end else if (bus.m_pix_ready) begin
            pix_valid <= 1'b0;
         end
      end
   end
endmodule
